// File: rtl/game_referee.sv
`default_nettype none
// ============================================================================
//  Module   : game_referee
//  Purpose  : Consumer side of the physics engine interface. Paces the engine
//             with one phys_en pulse per video frame during play and latches
//             each result frame into a stable snapshot for the renderer. Keeps
//             the score and runs the serve / play / point / match sequence.
//             It also flags a physics engine that fails to answer in time.
//  Revision : 1.0 - initial release
// ============================================================================
module game_referee #(
    parameter int WIN_SCORE     = 7,
    parameter int SERVE_FRAMES  = 60,
    parameter int POINT_FRAMES  = 90,
    parameter int VALID_TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       phys_valid,
    input  logic       phys_game_over,
    input  logic [1:0] phys_winner,
    input  logic [9:0] p1_x_i,
    input  logic [9:0] p1_y_i,
    input  logic [9:0] p2_x_i,
    input  logic [9:0] p2_y_i,
    input  logic [9:0] ball_x_i,
    input  logic [9:0] ball_y_i,
    output logic       phys_en,
    output logic [9:0] p1_x,
    output logic [9:0] p1_y,
    output logic [9:0] p2_x,
    output logic [9:0] p2_y,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [3:0] score_p1,
    output logic [3:0] score_p2,
    output logic [2:0] state,
    output logic       freeze_inputs,
    output logic [1:0] match_winner,
    output logic       phys_err
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int c_FRAME_MAX = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
    localparam int c_FRAME_W   = $clog2(c_FRAME_MAX + 1);
    localparam int c_TO_W      = (VALID_TIMEOUT > 1) ? $clog2(VALID_TIMEOUT) : 1;

    localparam logic [c_FRAME_W-1:0] c_SERVE_LAST = c_FRAME_W'(SERVE_FRAMES - 1);
    localparam logic [c_FRAME_W-1:0] c_POINT_LAST = c_FRAME_W'(POINT_FRAMES - 1);
    localparam logic [c_TO_W-1:0]    c_TO_LAST    = c_TO_W'(VALID_TIMEOUT - 1);
    localparam logic [3:0]           c_WIN        = 4'(WIN_SCORE);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SERVE      = 3'd1,
        ST_PLAY       = 3'd2,
        ST_POINT      = 3'd3,
        ST_MATCH_OVER = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                 state_q, state_d;
    logic [c_FRAME_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [3:0]             score_p1_q, score_p1_d;
    logic [3:0]             score_p2_q, score_p2_d;
    logic [1:0]             winner_q, winner_d;
    logic                   stale_q, stale_d;
    logic                   freeze_q;
    logic                   phys_en_q;

    // Response-window tracking for the engine handshake
    logic                   pend_q;
    logic [c_TO_W-1:0]      to_cnt_q;
    logic                   err_q;

    // Renderer snapshot
    logic [9:0]             p1_x_q, p1_y_q, p2_x_q, p2_y_q, ball_x_q, ball_y_q;

    // ------------------------------------------------------------------
    // Decode helpers
    // ------------------------------------------------------------------
    logic       w_score_ev;
    logic [3:0] w_p1_inc;
    logic [3:0] w_p2_inc;

    // A point only counts for a result that answers our own phys_en and is
    // not the engine's first step after play resumed (its flag is stale).
    assign w_score_ev = pend_q & phys_valid & ~stale_q & phys_game_over;
    assign w_p1_inc   = score_p1_q + 4'd1;
    assign w_p2_inc   = score_p2_q + 4'd1;

    // Next-state and score decisions
    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        score_p1_d  = score_p1_q;
        score_p2_d  = score_p2_q;
        winner_d    = winner_q;
        stale_d     = stale_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SERVE;
                end
            end

            ST_SERVE: begin
                if (frame_tick) begin
                    if (frame_cnt_q == c_SERVE_LAST) begin
                        state_d = ST_PLAY;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end
            end

            ST_PLAY: begin
                if (phys_valid) begin
                    stale_d = 1'b0;
                    if (w_score_ev) begin
                        // Unknown winner codes still end the rally.
                        state_d = ST_POINT;
                        if (phys_winner == 2'd1) begin
                            score_p1_d = w_p1_inc;
                            if (w_p1_inc == c_WIN) begin
                                state_d  = ST_MATCH_OVER;
                                winner_d = 2'd1;
                            end
                        end else if (phys_winner == 2'd2) begin
                            score_p2_d = w_p2_inc;
                            if (w_p2_inc == c_WIN) begin
                                state_d  = ST_MATCH_OVER;
                                winner_d = 2'd2;
                            end
                        end
                    end
                end
            end

            ST_POINT: begin
                if (frame_tick) begin
                    if (frame_cnt_q == c_POINT_LAST) begin
                        state_d = ST_SERVE;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end
            end

            ST_MATCH_OVER: begin
                if (start) begin
                    state_d    = ST_SERVE;
                    score_p1_d = 4'd0;
                    score_p2_d = 4'd0;
                    winner_d   = 2'd0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Every state entry restarts the frame count, so a tick landing on
        // the transition cycle is dropped. Entering play re-arms the guard.
        if (state_d != state_q) begin
            frame_cnt_d = '0;
            stale_d     = 1'b1;
        end
    end

    // Match FSM with registered outputs; phys_en follows a tick that is
    // seen while play is (or becomes) active.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            frame_cnt_q <= '0;
            score_p1_q  <= 4'd0;
            score_p2_q  <= 4'd0;
            winner_q    <= 2'd0;
            stale_q     <= 1'b0;
            freeze_q    <= 1'b1;
            phys_en_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            score_p1_q  <= score_p1_d;
            score_p2_q  <= score_p2_d;
            winner_q    <= winner_d;
            stale_q     <= stale_d;
            freeze_q    <= (state_d != ST_PLAY);
            phys_en_q   <= frame_tick & (state_d == ST_PLAY);
        end
    end

    // Open a response window on each phys_en; flag the engine if it stays silent
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q   <= 1'b0;
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else if (phys_en_q) begin
            pend_q   <= 1'b1;
            to_cnt_q <= '0;
        end else if (pend_q) begin
            if (phys_valid) begin
                pend_q <= 1'b0;
            end else if (to_cnt_q == c_TO_LAST) begin
                pend_q <= 1'b0;
                err_q  <= 1'b1;
            end else begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end
        end
    end

    // Latch every result frame the engine presents, requested or not
    always_ff @(posedge clk) begin
        if (rst) begin
            p1_x_q   <= 10'd0;
            p1_y_q   <= 10'd0;
            p2_x_q   <= 10'd0;
            p2_y_q   <= 10'd0;
            ball_x_q <= 10'd0;
            ball_y_q <= 10'd0;
        end else if (phys_valid) begin
            p1_x_q   <= p1_x_i;
            p1_y_q   <= p1_y_i;
            p2_x_q   <= p2_x_i;
            p2_y_q   <= p2_y_i;
            ball_x_q <= ball_x_i;
            ball_y_q <= ball_y_i;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign phys_en       = phys_en_q;
    assign p1_x          = p1_x_q;
    assign p1_y          = p1_y_q;
    assign p2_x          = p2_x_q;
    assign p2_y          = p2_y_q;
    assign ball_x        = ball_x_q;
    assign ball_y        = ball_y_q;
    assign score_p1      = score_p1_q;
    assign score_p2      = score_p2_q;
    assign state         = state_q;
    assign freeze_inputs = freeze_q;
    assign match_winner  = winner_q;
    assign phys_err      = err_q;

endmodule
`default_nettype wire
